// File: rtl/seq_shift_right_pkg.sv
// Shared ALU definitions for the sequential right shifter: widths, FSM
// encoding and the shift opcodes the ALU decoder maps onto `arith`.
package seq_shift_right_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // ALU opcodes that route to this block.
  localparam logic [3:0] ALU_OP_SRL = 4'd6;
  localparam logic [3:0] ALU_OP_SRA = 4'd7;

  // Decoder helper: SRA fills with the sign bit, SRL fills with zero.
  function automatic logic op_is_arith(input logic [3:0] op);
    return (op == ALU_OP_SRA);
  endfunction

endpackage

// File: rtl/seq_shift_right_shr_stage.sv
// One binary stage of a right shifter: shifts the operand by 2^k when
// enabled, back-filling the vacated top bits with `fill`.
module shr_stage #(
  parameter int WIDTH = seq_shift_right_pkg::WIDTH,
  parameter int SHW   = seq_shift_right_pkg::SHW
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [SHW-1:0]   k,
  input  logic             enable,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  // Select the 2^k shift for the active stage; pass through otherwise.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    result = operand;
    if (enable) begin
      for (int s = 0; s < SHW; s++) begin
        if (k == SHW'(s)) begin
          result = (operand >> (1 << s))
                 | ({WIDTH{fill}} & ~({WIDTH{1'b1}} >> (1 << s)));
        end
      end
    end
  end

endmodule

// File: rtl/seq_shift_right.sv
// Multi-cycle right shifter (SRL/SRA). One operation at a time: accept in
// IDLE, resolve one shift-amount bit per clock in SHIFT, present in DONE.
module seq_shift_right #(
  parameter int WIDTH = seq_shift_right_pkg::WIDTH,
  parameter int SHW   = seq_shift_right_pkg::SHW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             busy
);

  import seq_shift_right_pkg::*;

  localparam logic [SHW-1:0] LAST_STAGE = SHW'(SHW - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [SHW-1:0]   r_count;
  logic [WIDTH-1:0] r_operand;
  logic [SHW-1:0]   r_shamt;
  logic             r_arith;
  logic             r_fill;
  logic [WIDTH-1:0] w_stage_out;
  logic             w_accept;

  assign w_accept = (r_state == IDLE) && in_valid;

  // The single shared shift stage, stepped through k = 0..SHW-1 by the counter.
  shr_stage #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_stage (
    .operand (r_operand),
    .k       (r_count),
    .enable  (r_shamt[r_count]),
    .fill    (r_fill),
    .result  (w_stage_out)
  );

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next_state = SHIFT;
      end
      SHIFT: begin
        if (r_count == LAST_STAGE) w_next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  // Operand capture and per-stage update; the fill bit is fixed at acceptance.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count   <= '0;
      r_operand <= '0;
      r_shamt   <= '0;
      r_arith   <= 1'b0;
      r_fill    <= 1'b0;
    end else if (w_accept) begin
      r_count   <= '0;
      r_operand <= data_in;
      r_shamt   <= shamt;
      r_arith   <= arith;
      r_fill    <= arith & data_in[WIDTH-1];
    end else if (r_state == SHIFT) begin
      r_operand <= w_stage_out;
      r_count   <= (r_count == LAST_STAGE) ? '0 : r_count + 1'b1;
    end
  end

  assign data_out = r_operand;

  // r_arith is kept for debug visibility; only the derived fill drives the datapath.
  logic w_unused;
  assign w_unused = r_arith;

endmodule
